// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared field widths, range limits and FSM state encoding for
//               the alarm timekeeper.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_t;

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Modulo (MAX+1) up-counter with synchronous clear; wrap flags
//               the increment that takes q from MAX back to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int          W   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] c_max = W'(MAX);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= (r_q == c_max) ? '0 : r_q + W'(1);
        end
    end

    assign wrap = inc & (r_q == c_max);
    assign q    = r_q;

endmodule
`default_nettype wire

// File: rtl/alarm_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : alarm_timekeeper
// Description : hh:mm:ss clock driven by the divider square wave, with a
//               programmable hh:mm alarm and an IDLE/RINGING/SNOOZED ringer.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             set_time,
    input  logic             set_alarm,
    input  logic             inc_hour,
    input  logic             inc_min,
    input  logic             alarm_en,
    input  logic             snooze,
    input  logic             stop,
    output logic [HR_W-1:0]  hours,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic [HR_W-1:0]  al_hours,
    output logic [MIN_W-1:0] al_minutes,
    output logic             sec_tick,
    output logic             ringing
);

    localparam logic [5:0]       c_ring_last = 6'(RING_SECS - 1);
    localparam logic [MIN_W:0]   c_snooze    = 7'(SNOOZE_MINS);
    localparam logic [MIN_W:0]   c_min_mod   = 7'd60;

    logic             r_tick_q;
    logic             r_sec_tick;
    alarm_state_t     r_state;
    alarm_state_t     w_state_nxt;
    logic [5:0]       r_ring_cnt;
    logic [5:0]       w_ring_cnt_nxt;
    logic [HR_W-1:0]  r_tgt_hr;
    logic [MIN_W-1:0] r_tgt_min;
    logic             w_tgt_load;

    logic             w_edge;
    logic             w_count;
    logic             w_sec_wrap;
    logic             w_min_inc;
    logic             w_min_wrap;
    logic             w_hr_inc;
    logic             w_hr_wrap;
    logic             w_unused_al_min_wrap;
    logic             w_unused_al_hr_wrap;
    logic [HR_W-1:0]  w_next_hr;
    logic [MIN_W-1:0] w_next_min;
    logic             w_alarm_hit;
    logic             w_snooze_hit;
    logic [MIN_W:0]   w_snz_sum;
    logic             w_snz_carry;
    logic [MIN_W-1:0] w_snz_min;
    logic [HR_W-1:0]  w_snz_hr;

    assign w_edge  = tick_in & ~r_tick_q;
    assign w_count = w_edge & ~set_time;

    // Carries only ripple while counting; in set mode each field is independent.
    assign w_min_inc = w_sec_wrap | (set_time & inc_min);
    assign w_hr_inc  = (w_sec_wrap & w_min_wrap) | (set_time & inc_hour);

    wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_count),
        .clr  (set_time),
        .q    (seconds),
        .wrap (w_sec_wrap)
    );

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_min_inc),
        .clr  (1'b0),
        .q    (minutes),
        .wrap (w_min_wrap)
    );

    wrap_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_hr_inc),
        .clr  (1'b0),
        .q    (hours),
        .wrap (w_hr_wrap)
    );

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_al_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (~set_time & set_alarm & inc_min),
        .clr  (1'b0),
        .q    (al_minutes),
        .wrap (w_unused_al_min_wrap)
    );

    wrap_counter #(.W(HR_W), .MAX(HR_MAX)) u_al_hr (
        .clk  (clk),
        .rst  (rst),
        .inc  (~set_time & set_alarm & inc_hour),
        .clr  (1'b0),
        .q    (al_hours),
        .wrap (w_unused_al_hr_wrap)
    );

    // hh:mm that the counters will hold after a :59 -> :00 rollover.
    assign w_next_min = w_min_wrap ? '0 : minutes + MIN_W'(1);
    assign w_next_hr  = w_min_wrap ? (w_hr_wrap ? '0 : hours + HR_W'(1)) : hours;

    assign w_alarm_hit  = w_sec_wrap & (w_next_hr == al_hours) & (w_next_min == al_minutes);
    assign w_snooze_hit = w_sec_wrap & (w_next_hr == r_tgt_hr) & (w_next_min == r_tgt_min);

    assign w_snz_sum   = {1'b0, minutes} + c_snooze;
    assign w_snz_carry = (w_snz_sum >= c_min_mod);
    assign w_snz_min   = w_snz_carry ? MIN_W'(w_snz_sum - c_min_mod) : w_snz_sum[MIN_W-1:0];
    assign w_snz_hr    = w_snz_carry ? ((hours == HR_MAX) ? '0 : hours + HR_W'(1)) : hours;

    always_comb begin
        w_state_nxt    = r_state;
        w_ring_cnt_nxt = r_ring_cnt;
        w_tgt_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (alarm_en && w_alarm_hit) begin
                    w_state_nxt    = ST_RINGING;
                    w_ring_cnt_nxt = '0;
                end
            end
            ST_RINGING: begin
                if (!alarm_en || stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (snooze) begin
                    w_state_nxt = ST_SNOOZED;
                    w_tgt_load  = 1'b1;
                end else if (w_edge) begin
                    if (r_ring_cnt == c_ring_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt + 6'd1;
                    end
                end
            end
            ST_SNOOZED: begin
                if (!alarm_en || stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_snooze_hit) begin
                    w_state_nxt    = ST_RINGING;
                    w_ring_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_q   <= 1'b0;
            r_sec_tick <= 1'b0;
            r_state    <= ST_IDLE;
            r_ring_cnt <= '0;
            r_tgt_hr   <= '0;
            r_tgt_min  <= '0;
        end else begin
            r_tick_q   <= tick_in;
            r_sec_tick <= w_count;
            r_state    <= w_state_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
            if (w_tgt_load) begin
                r_tgt_hr  <= w_snz_hr;
                r_tgt_min <= w_snz_min;
            end
        end
    end

    assign sec_tick = r_sec_tick;
    assign ringing  = (r_state == ST_RINGING);

endmodule
`default_nettype wire

// File: tb/tb_alarm_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_timekeeper
// Description : Scoreboard bench for alarm_timekeeper; stimulus queues the
//               expected response, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_timekeeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0, set_time = 1'b0, set_alarm = 1'b0;
    logic       inc_hour = 1'b0, inc_min = 1'b0, alarm_en = 1'b0;
    logic       snooze = 1'b0, stop = 1'b0;
    logic [4:0] hours, al_hours;
    logic [5:0] minutes, seconds, al_minutes;
    logic       sec_tick, ringing;

    always #5 clk = ~clk;

    alarm_timekeeper #(.RING_SECS(60), .SNOOZE_MINS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .set_time   (set_time),
        .set_alarm  (set_alarm),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .alarm_en   (alarm_en),
        .snooze     (snooze),
        .stop       (stop),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .al_hours   (al_hours),
        .al_minutes (al_minutes),
        .sec_tick   (sec_tick),
        .ringing    (ringing)
    );

    typedef struct {
        string name;
        int    hh, mm, ss, ah, am;
        bit    ring, tick;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic chk = 1'b0;

    // Reference time/alarm the stimulus believes the DUT holds.
    int m_h = 0, m_m = 0, m_s = 0, m_ah = 0, m_am = 0;
    bit m_ring = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [29:0] act, req;
        if (!rst && (sec_tick !== 1'b0 || chk)) begin
            n_checks++;
            act = {hours, minutes, seconds, al_hours, al_minutes, ringing, sec_tick};
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_output: sec_tick=%b ringing=%b time %0d:%0d:%0d, nothing expected",
                         sec_tick, ringing, hours, minutes, seconds);
            end else begin
                e   = sb.pop_front();
                req = {5'(e.hh), 6'(e.mm), 6'(e.ss), 5'(e.ah), 6'(e.am), e.ring, e.tick};
                if (act !== req) begin
                    n_errors++;
                    $display("FAIL %s: got %0d:%0d:%0d al %0d:%0d ring=%b tick=%b, want %0d:%0d:%0d al %0d:%0d ring=%b tick=%b",
                             e.name, hours, minutes, seconds, al_hours, al_minutes, ringing, sec_tick,
                             e.hh, e.mm, e.ss, e.ah, e.am, e.ring, e.tick);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int hh, input int mm, input int ss,
                        input int ah, input int am, input bit ring, input bit tk);
        exp_t e;
        e.name = name; e.hh = hh; e.mm = mm; e.ss = ss;
        e.ah = ah; e.am = am; e.ring = ring; e.tick = tk;
        sb.push_back(e);
    endtask

    // Check of a steady (non-tick) cycle against hand-computed values.
    task automatic expect_now(input string name, input int hh, input int mm, input int ss,
                              input int ah, input int am, input bit ring);
        push(name, hh, mm, ss, ah, am, ring, 1'b0);
        chk = 1'b1;
        cyc(1);
        chk = 1'b0;
    endtask

    task automatic tick(input string name);
        m_s++;
        if (m_s == 60) begin
            m_s = 0;
            m_m++;
            if (m_m == 60) begin
                m_m = 0;
                m_h = (m_h + 1) % 24;
            end
        end
        push(name, m_h, m_m, m_s, m_ah, m_am, m_ring, 1'b1);
        tick_in = 1'b1;
        cyc(1);
        tick_in = 1'b0;
        cyc(1);
    endtask

    task automatic run_to(input int hh, input int mm, input int ss, input string name);
        int guard = 0;
        while (!(m_h == hh && m_m == mm && m_s == ss)) begin
            tick(name);
            guard++;
            if (guard > 4000) begin
                n_checks++;
                n_errors++;
                $display("FAIL run_to_bound: gave up at %0d:%0d:%0d, want %0d:%0d:%0d",
                         m_h, m_m, m_s, hh, mm, ss);
                break;
            end
        end
    endtask

    task automatic pulse_hour();
        inc_hour = 1'b1; cyc(1); inc_hour = 1'b0; cyc(1);
    endtask

    task automatic pulse_min();
        inc_min = 1'b1; cyc(1); inc_min = 1'b0; cyc(1);
    endtask

    task automatic set_clock(input int hh, input int mm);
        set_time = 1'b1;
        cyc(1);
        m_s = 0;
        while (m_h != hh) begin pulse_hour(); m_h = (m_h + 1) % 24; end
        while (m_m != mm) begin pulse_min();  m_m = (m_m + 1) % 60; end
        set_time = 1'b0;
        cyc(1);
    endtask

    task automatic set_al(input int hh, input int mm);
        set_alarm = 1'b1;
        while (m_ah != hh) begin pulse_hour(); m_ah = (m_ah + 1) % 24; end
        while (m_am != mm) begin pulse_min();  m_am = (m_am + 1) % 60; end
        set_alarm = 1'b0;
        cyc(1);
    endtask

    task automatic reset_dut();
        rst = 1'b1; cyc(1); rst = 1'b0;
        m_h = 0; m_m = 0; m_s = 0; m_ah = 0; m_am = 0; m_ring = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        expect_now("reset_state", 0, 0, 0, 0, 0, 1'b0);

        // Alarm at 07:30 and 60-second auto timeout
        set_al(7, 30);
        set_clock(7, 29);
        expect_now("preset_0729", 7, 29, 0, 7, 30, 1'b0);
        run_to(7, 29, 59, "count_to_0729_59");
        alarm_en = 1'b1;
        m_ring = 1'b1;
        tick("alarm_hit_0730");
        expect_now("ring_start", 7, 30, 0, 7, 30, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            m_ring = (i < 60);
            tick("ring_count");
        end
        expect_now("ring_timeout", 7, 31, 0, 7, 30, 1'b0);

        // Reset while ringing
        set_al(7, 32);
        run_to(7, 31, 59, "count_to_0731_59");
        m_ring = 1'b1;
        tick("ring_0732");
        tick("ring_0732_hold");
        reset_dut();
        alarm_en = 1'b0;
        expect_now("reset_mid_ring", 0, 0, 0, 0, 0, 1'b0);

        // Midnight rollover and held tick_in
        set_clock(23, 59);
        run_to(23, 59, 58, "count_to_235958");
        expect_now("pre_midnight", 23, 59, 58, 0, 0, 1'b0);
        tick("to_235959");
        m_h = 0; m_m = 0; m_s = 0;
        push("midnight", 0, 0, 0, 0, 0, 1'b0, 1'b1);
        tick_in = 1'b1;
        cyc(6);
        tick_in = 1'b0;
        cyc(2);
        expect_now("hold_no_extra", 0, 0, 0, 0, 0, 1'b0);

        // Snooze across midnight: 23:58 + 5 min -> 00:03
        set_al(23, 58);
        set_clock(23, 57);
        alarm_en = 1'b1;
        run_to(23, 57, 59, "count_to_235759");
        m_ring = 1'b1;
        tick("ring_2358");
        snooze = 1'b1; cyc(1); snooze = 1'b0;
        m_ring = 1'b0;
        expect_now("snoozed", 23, 58, 0, 23, 58, 1'b0);
        run_to(0, 2, 59, "snooze_wait");
        m_ring = 1'b1;
        tick("snooze_rering");
        expect_now("rering_0003", 0, 3, 0, 23, 58, 1'b1);
        stop = 1'b1; cyc(1); stop = 1'b0;
        m_ring = 1'b0;
        expect_now("stopped", 0, 3, 0, 23, 58, 1'b0);

        // snooze+stop together, then alarm_en drop while snoozed
        set_al(0, 4);
        run_to(0, 3, 59, "count_to_0003_59");
        m_ring = 1'b1;
        tick("ring_0004");
        snooze = 1'b1; stop = 1'b1; cyc(1); snooze = 1'b0; stop = 1'b0;
        m_ring = 1'b0;
        expect_now("snooze_stop", 0, 4, 0, 0, 4, 1'b0);
        run_to(0, 9, 0, "idle_after_stop");
        expect_now("no_ring_at_0009", 0, 9, 0, 0, 4, 1'b0);
        set_al(0, 10);
        run_to(0, 9, 59, "count_to_0009_59");
        m_ring = 1'b1;
        tick("ring_0010");
        snooze = 1'b1; cyc(1); snooze = 1'b0;
        m_ring = 1'b0;
        alarm_en = 1'b0;
        cyc(1);
        run_to(0, 15, 0, "disabled_wait");
        expect_now("no_rering_disabled", 0, 15, 0, 0, 10, 1'b0);

        // Time-set mode: no carries, edges ignored, set_time wins
        reset_dut();
        set_time = 1'b1;
        for (int i = 0; i < 61; i++) begin
            inc_min = 1'b1; tick_in = 1'b1;
            cyc(1);
            inc_min = 1'b0; tick_in = 1'b0;
            cyc(1);
        end
        expect_now("set_min_x61", 0, 1, 0, 0, 0, 1'b0);
        set_alarm = 1'b1;
        pulse_hour();
        expect_now("both_modes", 1, 1, 0, 0, 0, 1'b0);
        set_time = 1'b0;
        set_alarm = 1'b0;
        cyc(1);
        pulse_hour();
        pulse_min();
        expect_now("no_mode", 1, 1, 0, 0, 0, 1'b0);
        set_alarm = 1'b1;
        pulse_min();
        m_h = 1; m_m = 1; m_s = 0; m_ah = 0; m_am = 1;
        tick("alarm_mode_runs");
        set_alarm = 1'b0;
        expect_now("alarm_mode_edit", 1, 1, 1, 0, 1, 1'b0);

        cyc(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d responses still pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
